// File: rtl/uart_arb_pkg.sv
// Shared types, widths and helpers for the UART transmit-port arbiter.
package uart_arb_pkg;

  localparam int unsigned GRANT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  // Next index in round-robin order, wrapping at n.
  function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] idx,
                                                  input int unsigned       n);
    int unsigned nxt;
    nxt = 32'(idx) + 32'd1;
    if (nxt >= n) begin
      nxt = 32'd0;
    end
    return GRANT_W'(nxt);
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Round-robin requester search starting just after the last served client.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [GRANT_W-1:0] last,
  output logic               found,
  output logic [GRANT_W-1:0] idx
);

  logic [GRANT_W-1:0] cand;

  // Walk N_REQ candidates from last+1 with wrap; keep the first valid one.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = rr_next(last, N_REQ);
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && (|(req_valid & (N_REQ'(1) << cand)))) begin
        found = 1'b1;
        idx   = cand;
      end
      cand = rr_next(cand, N_REQ);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing the UART TX FIFO write port,
// with optional source-ID header byte and a mid-packet stall watchdog.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter bit          ADD_HEADER = 1'b1,
  parameter logic [7:0]  HDR_BASE   = 8'hA0,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     abort,
  output logic [7:0]           wdata,
  output logic                 wruart,
  input  logic                 txfull,
  output logic                 busy,
  output logic [GRANT_W-1:0]   grant_id
);

  localparam int unsigned        CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(TIMEOUT - 1);
  localparam logic [GRANT_W-1:0] LAST_RST = GRANT_W'(N_REQ - 1);

  state_t             state;
  state_t             state_nxt;
  logic [GRANT_W-1:0] grant_nxt;
  logic [GRANT_W-1:0] last_q;
  logic [GRANT_W-1:0] last_nxt;
  logic [CNT_W-1:0]   wd_cnt;
  logic [CNT_W-1:0]   wd_cnt_nxt;

  logic               pick_found;
  logic [GRANT_W-1:0] pick_idx;

  logic [N_REQ-1:0]   g_onehot;
  logic               g_valid;
  logic               g_last;
  logic [7:0]         g_data;

  uart_rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req_valid (req_valid),
    .last      (last_q),
    .found     (pick_found),
    .idx       (pick_idx)
  );

  // Select the granted client's valid/last/data lanes.
  always_comb begin
    g_onehot = N_REQ'(1) << grant_id;
    g_valid  = |(req_valid & g_onehot);
    g_last   = |(req_last & g_onehot);
    g_data   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (g_onehot[i]) begin
        g_data = g_data | req_data[8*i +: 8];
      end
    end
  end

  // State, grant, round-robin pointer and watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      last_q   <= LAST_RST;
      wd_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      last_q   <= last_nxt;
      wd_cnt   <= wd_cnt_nxt;
    end
  end

  // Next-state and port-facing outputs.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_id;
    last_nxt   = last_q;
    wd_cnt_nxt = wd_cnt;
    req_ready  = '0;
    abort      = '0;
    wruart     = 1'b0;
    wdata      = '0;
    busy       = (state != IDLE);

    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nxt  = pick_idx;
          state_nxt  = ADD_HEADER ? HDR : DATA;
          wd_cnt_nxt = '0;
        end
      end

      HDR: begin
        wruart = ~txfull;
        wdata  = HDR_BASE | 8'(grant_id);
        if (!txfull) begin
          state_nxt  = DATA;
          wd_cnt_nxt = '0;
        end
      end

      DATA: begin
        wdata  = g_data;
        wruart = g_valid & ~txfull;
        if (!txfull) begin
          req_ready = g_onehot;
        end
        if (g_valid) begin
          // A full FIFO with a byte on offer is a stall, not client idleness.
          if (!txfull) begin
            wd_cnt_nxt = '0;
            if (g_last) begin
              state_nxt = IDLE;
              last_nxt  = grant_id;
            end
          end
        end else if (wd_cnt == CNT_MAX) begin
          abort      = g_onehot;
          state_nxt  = IDLE;
          last_nxt   = grant_id;
          wd_cnt_nxt = '0;
        end else begin
          wd_cnt_nxt = wd_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin packet arbiter that shares the single UART transmit FIFO write port (wdata/wruart/txfull) between N_REQ client requesters.
- Each client streams a byte packet over a valid/ready/last interface.
- Once granted, a client holds the port until its last byte (packet lock).
- An optional source-ID header byte is inserted ahead of each packet.
- A stall watchdog aborts a client that stops supplying bytes mid-packet.
- Sits between client logic and the UART wruart/wdata/txfull interface.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADD_HEADER, 1, 1 = emit header byte (HDR_BASE | grant index) before each packet; 0 = no header
HDR_BASE, 8'hA0, header byte base; low 3 bits must be 0
TIMEOUT, 1024, idle cycles allowed in DATA state before abort (>= 2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  N_REQ  per-client byte valid
req_data  in  8*N_REQ  per-client byte; client i on bits [8i+7:8i]
req_last  in  N_REQ  per-client final byte of packet, qualified by req_valid
req_ready  out  N_REQ  per-client byte accepted this cycle
abort  out  N_REQ  one-cycle pulse: client's packet aborted by watchdog
wdata  out  8  byte to UART TX FIFO
wruart  out  1  TX FIFO write strobe
txfull  in  1  TX FIFO full
busy  out  1  state != IDLE
grant_id  out  3  current/last granted index

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high.
- Reset values: state=IDLE, grant_id=0, rr pointer last=N_REQ-1, watchdog=0. All outputs 0: req_ready, abort, wruart, wdata, busy.
- States: IDLE, HDR, DATA.
- IDLE:
  - Pick the first i with req_valid[i], searching from (last+1) mod N_REQ upward with wrap.
  - If one is found: grant_id<=i, then HDR (ADD_HEADER=1) or DATA (ADD_HEADER=0) next cycle.
  - No write and no ready in IDLE.
- HDR:
  - wruart = ~txfull; wdata = HDR_BASE | grant_id.
  - On write, go to DATA. While txfull, hold HDR.
- DATA (combinational outputs, g = grant_id):
  - req_ready[g] = ~txfull.
  - wruart = req_valid[g] & ~txfull.
  - wdata = req_data[g].
  - All other req_ready bits = 0.
- Transfer: wruart=1 in DATA.
  - Transfer with req_last[g] -> IDLE next cycle, last<=g.
- Invariants: wruart is never asserted while txfull=1. Exactly one FIFO write per accepted byte.
- Latency: req_valid rising in IDLE at cycle t -> header write at t+1 -> first data write at t+2 at the earliest. With ADD_HEADER=0, first data write at t+1.
- Back-to-back: after the last byte, there is one IDLE cycle before the next grant. A client requesting continuously alternates fairly with the others.
- Watchdog (DATA only):
  - Counter increments on cycles with req_valid[g]=0. It holds on txfull stalls and clears on every transfer and on entering DATA.
  - When the counter reaches TIMEOUT-1 with req_valid[g] still low: abort[g] pulses for that cycle, next state IDLE, last<=g, counter cleared.
  - No byte is written in the abort cycle.
- Simultaneous events:
  - req_valid & req_last & txfull: no transfer; wait.
  - Abort and valid in the same cycle cannot occur, because valid clears the counter first.
- Non-granted clients' req_valid/req_last are ignored; clients must hold valid/data until ready.
- Reset mid-packet: immediate return to IDLE next edge, outputs zeroed. A partial packet may remain in the FIFO; this is accepted.
- Widths: counter width $clog2(TIMEOUT); grant index width 3, zero-extended.

Decomposition:
- Package uart_arb_pkg:
  - state enum {IDLE, HDR, DATA};
  - GRANT_W=3;
  - a function for the next round-robin index.
- Sub-module uart_rr_picker: combinational; inputs req_valid and last; outputs found and idx.

Test Plan:
- Single client 1 (N_REQ=4, ADD_HEADER=1) sends packet 11,22,33(last) with txfull=0 -> FIFO receives A1,11,22,33 on consecutive cycles; busy falls the cycle after 33.
- Clients 0 and 2 request simultaneously from reset (last=3) -> client 0 packet first (A0,...), then client 2 (A2,...); req_ready[2] stays 0 throughout client 0's packet.
- txfull held high for 5 cycles mid-packet -> wruart=0 and req_ready=0 during stall; no byte lost or duplicated; watchdog does not fire.
- Client 3 drops req_valid after its header for TIMEOUT cycles (TIMEOUT=16) -> abort[3] pulses at the 16th idle cycle; arbiter returns to IDLE; next requester is granted.
- Assert rst during DATA of client 1 -> next cycle wruart=0, busy=0, grant_id=0; after release, a new request from client 0 is granted normally.
- ADD_HEADER=0, all four clients continuously sending 2-byte packets -> grant order 0,1,2,3,0,...; no header bytes appear in the FIFO.
